// File: rtl/debug_pkg.sv
// Shared constants and FSM encoding for the register-file debug dump path.
// REGDUMP_HEADER_EN adds the HDR state to the encoding.
package debug_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DUMP_HDR = 8'hA5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HALT_WAIT = 3'd1;
  localparam logic [2:0] ST_HDR       = 3'd2;
  localparam logic [2:0] ST_READ      = 3'd3;
  localparam logic [2:0] ST_SEND      = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    HALT_WAIT = ST_HALT_WAIT,
`ifdef REGDUMP_HEADER_EN
    HDR       = ST_HDR,
`endif
    READ      = ST_READ,
    SEND      = ST_SEND,
    DONE      = ST_DONE
  } state_t;

  // Counter width that stays legal when only a single item is counted.
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_seq_if.sv
// Byte stream towards the debug UART transmitter (valid/ready handshake).
interface regfile_dump_seq_if;
  import debug_pkg::*;

  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/byte_serializer.sv
// B-bit load/shift register emitting bytes MSB first, with a byte counter
// that flags the final byte of the word.
module byte_serializer
  import debug_pkg::*;
#(
  parameter int B = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [B-1:0]      din,
  input  logic              valid,
  input  logic              ready,
  output logic [BYTE_W-1:0] dout,
  output logic              fire,
  output logic              last
);

  localparam int NB = B / BYTE_W;
  localparam int CW = ctr_w(NB);

  logic [B-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign fire = valid && ready;
  assign dout = shift_q[B-1 -: BYTE_W];
  assign last = (cnt_q == CW'(NB - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = din;
      cnt_d   = '0;
    end else if (fire) begin
      shift_d = shift_q << BYTE_W;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_dump_seq.sv
// Debug dump sequencer: halts the pipeline, borrows register-file read port 1
// and streams every register MSB byte first. REGDUMP_HEADER_EN adds a 0xA5 lead byte.
module regfile_dump_seq
  import debug_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] pipe_r_addr,
  output logic [W-1:0] rf_r_addr,
  input  logic [B-1:0] rf_r_data,
  output logic         halt_req,
  input  logic         halt_ack,
  output logic         busy,
  output logic         done,
  regfile_dump_seq_if.master out_if
);

  localparam logic [W-1:0] ADDR_MAX = '1;

  state_t        state_q, state_d;
  logic [W-1:0]  addr_q, addr_d;

  logic              ser_load;
  logic              ser_valid;
  logic              ser_fire;
  logic              ser_last;
  logic [BYTE_W-1:0] ser_byte;
  logic              hdr_valid;

  byte_serializer #(
    .B(B)
  ) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .din   (rf_r_data),
    .valid (ser_valid),
    .ready (out_if.out_ready),
    .dout  (ser_byte),
    .fire  (ser_fire),
    .last  (ser_last)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ser_load  = 1'b0;
    ser_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HALT_WAIT;
          addr_d  = '0;
        end
      end
      HALT_WAIT: begin
        if (halt_ack) begin
`ifdef REGDUMP_HEADER_EN
          state_d = HDR;
`else
          state_d = READ;
`endif
        end
      end
`ifdef REGDUMP_HEADER_EN
      HDR: begin
        if (out_if.out_ready) begin
          state_d = READ;
        end
      end
`endif
      READ: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        ser_valid = 1'b1;
        // Exit is decided on the current address so the counter never wraps.
        if (ser_fire && ser_last) begin
          if (addr_q == ADDR_MAX) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef REGDUMP_HEADER_EN
  assign hdr_valid = (state_q == HDR);
`else
  assign hdr_valid = 1'b0;
`endif

  assign rf_r_addr        = (state_q == IDLE) ? pipe_r_addr : addr_q;
  assign busy             = (state_q != IDLE);
  assign halt_req         = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign out_if.out_valid = ser_valid || hdr_valid;
  assign out_if.out_data  = hdr_valid ? DUMP_HDR :
                            (ser_valid ? ser_byte : '0);

endmodule

// File: tb/tb_regfile_dump_seq.sv
// Directed bench for regfile_dump_seq: reset, pass-through, full dumps with and
// without backpressure, halt handshake, start while busy and reset mid-dump.
module tb_regfile_dump_seq;

  localparam int B      = 32;
  localparam int W      = 5;
  localparam int NREG   = 32;
`ifdef REGDUMP_HEADER_EN
  localparam int HDR_N  = 1;
`else
  localparam int HDR_N  = 0;
`endif
  localparam int EXP_BYTES = NREG * 4 + HDR_N;
  localparam int EXP_CYC   = 162 + HDR_N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] pipe_r_addr;
  logic [W-1:0] rf_r_addr;
  logic [B-1:0] rf_r_data;
  logic         halt_req;
  logic         halt_ack;
  logic         busy;
  logic         done;

  logic [B-1:0] regs [NREG];

  regfile_dump_seq_if bus ();

  regfile_dump_seq #(
    .B(B),
    .W(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pipe_r_addr (pipe_r_addr),
    .rf_r_addr   (rf_r_addr),
    .rf_r_data   (rf_r_data),
    .halt_req    (halt_req),
    .halt_ack    (halt_ack),
    .busy        (busy),
    .done        (done),
    .out_if      (bus)
  );

  assign rf_r_data = regs[rf_r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  logic [7:0] got [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    int j;
    logic [31:0] w;
    if (HDR_N == 1 && k == 0) return 8'hA5;
    j = k - HDR_N;
    w = 32'h1000_0000 + 32'(j / 4);
    return w[31 - 8 * (j % 4) -: 8];
  endfunction

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(EXP_BYTES));
    for (int k = 0; k < got.size() && k < EXP_BYTES; k++) begin
      check($sformatf("%s_byte%0d", tag, k), 32'(got[k]), 32'(exp_byte(k)));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle count starts at 1 for the first edge after start was driven.
  task automatic run_to_done(input int bound, input bit rand_ready, output int cyc);
    cyc = 1;
    while (!done) begin
      if (cyc >= bound) begin
        check("done_timeout", 32'(done), 32'd1);
        break;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Byte capture, stall stability and done counting, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_data", 32'(bus.out_data), 32'(prev_data));
    end
    prev_stall <= rst_n && bus.out_valid && !bus.out_ready;
    prev_data  <= bus.out_data;
    if (rst_n && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (rst_n && done) done_cnt++;
  end

  initial begin
    int cyc;
    int waited;
    for (int i = 0; i < NREG; i++) regs[i] = 32'h1000_0000 + 32'(i);
    rst_n         = 1'b0;
    start         = 1'b0;
    halt_ack      = 1'b0;
    bus.out_ready = 1'b0;
    pipe_r_addr   = 5'd7;

    // Reset state
    #12;
    check("rst_halt_req", 32'(halt_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rf_addr", 32'(rf_r_addr), 32'd7);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle pass-through
    pipe_r_addr = 5'd3;
    #1 check("idle_addr3", 32'(rf_r_addr), 32'd3);
    pipe_r_addr = 5'd17;
    #1 check("idle_addr17", 32'(rf_r_addr), 32'd17);
    pipe_r_addr = 5'd31;
    #1 check("idle_addr31", 32'(rf_r_addr), 32'd31);

    // Full dump, no backpressure; a start in the DONE cycle must be ignored
    halt_ack      = 1'b1;
    bus.out_ready = 1'b1;
    got.delete();
    done_cnt = 0;
    pulse_start();
    check("halt_req_rise", 32'(halt_req), 32'd1);
    run_to_done(1000, 1'b0, cyc);
    check("nobp_done_cycle", 32'(cyc), 32'(EXP_CYC));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("after_done_done", 32'(done), 32'd0);
    check("after_done_busy", 32'(busy), 32'd0);
    check("after_done_halt", 32'(halt_req), 32'd0);
    @(posedge clk);
    #1 check("start_in_done_ignored", 32'(busy), 32'd0);
    check("nobp_done_pulses", 32'(done_cnt), 32'd1);
    check_stream("nobp");

    // Backpressure with random out_ready
    got.delete();
    done_cnt = 0;
    pulse_start();
    run_to_done(3000, 1'b1, cyc);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_busy_after", 32'(busy), 32'd0);
    check("bp_done_pulses", 32'(done_cnt), 32'd1);
    check_stream("bp");

    // Halt handshake held off for 10 cycles
    got.delete();
    done_cnt = 0;
    halt_ack    = 1'b0;
    pipe_r_addr = 5'd9;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hw_halt_req", 32'(halt_req), 32'd1);
      check("hw_out_valid", 32'(bus.out_valid), 32'd0);
      check("hw_rf_addr", 32'(rf_r_addr), 32'd0);
    end
    halt_ack = 1'b1;
    run_to_done(1000, 1'b0, cyc);
    @(posedge clk);
    #1 check("hw_done_pulses", 32'(done_cnt), 32'd1);
    check_stream("hw");

    // Second start mid-dump ignored; halt_ack dropping mid-dump ignored
    got.delete();
    done_cnt = 0;
    pulse_start();
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    halt_ack = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    run_to_done(1000, 1'b0, cyc);
    halt_ack = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("busy_restart_busy", 32'(busy), 32'd0);
    check("busy_restart_done_pulses", 32'(done_cnt), 32'd1);
    check_stream("busy_restart");

    // Reset mid-dump after 20 bytes
    got.delete();
    done_cnt = 0;
    pipe_r_addr = 5'd21;
    pulse_start();
    waited = 0;
    while (got.size() < 20 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("mid_rst_reached20", 32'(got.size() >= 20), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_halt_req", 32'(halt_req), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rf_addr", 32'(rf_r_addr), 32'd21);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1 check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
